// File: rtl/simmem_release_arbiter.sv
// simmem_release_arbiter
// Picks one releasable slot per cycle from the delay calculator's release
// enables and presents its IID through a registered valid/ready stage.
// Each accepted release also produces a one-hot confirmation pulse back to
// the delay calculator.
// A slot is granted once while it stays valid. Its grant is dropped when
// the bank frees the slot, so the slot can be presented again later.
// Optional feature macro: SIMMEM_RELEASE_RR_EN
//   defined   -> round-robin selection starting at rr_q
//   undefined -> fixed priority, lowest eligible index wins (no rr_q)
`timescale 1ns/1ps

module simmem_release_arbiter #(
    parameter int Capa = 16,
    parameter int IidW = $clog2(Capa)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [Capa-1:0]   release_en_mhot_i,
    input  logic [Capa-1:0]   slot_valid_mhot_i,
    output logic              rel_valid_o,
    output logic [IidW-1:0]   rel_iid_o,
    input  logic              rel_ready_i,
    output logic [Capa-1:0]   released_iid_onehot_o,
    output logic [IidW:0]     pending_cnt_o
);

    // Number of set bits in a slot mask.
    function automatic logic [IidW:0] popcount(input logic [Capa-1:0] vec);
        logic [IidW:0] cnt;
        cnt = '0;
        for (int i = 0; i < Capa; i++) begin
            cnt = cnt + {{IidW{1'b0}}, vec[i]};
        end
        return cnt;
    endfunction

    // Expands an IID into its one-hot slot mask.
    function automatic logic [Capa-1:0] iid_to_onehot(input logic [IidW-1:0] iid);
        logic [Capa-1:0] mask;
        mask = '0;
        for (int i = 0; i < Capa; i++) begin
            if (iid == IidW'(i)) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

`ifdef SIMMEM_RELEASE_RR_EN
    // First eligible index at or after start, wrapping modulo Capa.
    function automatic logic [IidW-1:0] rr_pick(input logic [Capa-1:0] elig,
                                                input logic [IidW-1:0] start);
        logic [IidW-1:0] pick;
        logic            found;
        int              idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < Capa; i++) begin
            idx = ((int'(start) + i) >= Capa) ? (int'(start) + i - Capa)
                                              : (int'(start) + i);
            if (!found && elig[idx]) begin
                pick  = IidW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction
`else
    // Lowest eligible index.
    function automatic logic [IidW-1:0] fixed_pick(input logic [Capa-1:0] elig);
        logic [IidW-1:0] pick;
        logic            found;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < Capa; i++) begin
            if (!found && elig[i]) begin
                pick  = IidW'(i);
                found = 1'b1;
            end
        end
        return pick;
    endfunction
`endif

    // State registers and their next-state values.
    logic              rel_valid_q;
    logic [IidW-1:0]   rel_iid_q;
    logic [Capa-1:0]   granted_q;
    logic [IidW:0]     pending_q;

    logic              rel_valid_d;
    logic [IidW-1:0]   rel_iid_d;
    logic [Capa-1:0]   granted_d;
    logic [IidW:0]     pending_d;

    logic [Capa-1:0]   eligible;
    logic              any_eligible;
    logic              load;
    logic [IidW-1:0]   winner;
    logic [Capa-1:0]   set_mask;

`ifdef SIMMEM_RELEASE_RR_EN
    logic [IidW-1:0]   rr_q;
    logic [IidW-1:0]   rr_d;
`endif

    assign eligible     = release_en_mhot_i & slot_valid_mhot_i & ~granted_q;
    assign any_eligible = |eligible;
    // The output stage may take a new IID when empty or being drained.
    assign load         = !rel_valid_q || rel_ready_i;

    // Winner selection among eligible slots.
    always_comb begin
        winner = '0;
`ifdef SIMMEM_RELEASE_RR_EN
        winner = rr_pick(eligible, rr_q);
`else
        winner = fixed_pick(eligible);
`endif
    end

    // Next-state for the output stage, grant mask and pending count.
    always_comb begin
        rel_valid_d = rel_valid_q;
        rel_iid_d   = rel_iid_q;
        set_mask    = '0;
`ifdef SIMMEM_RELEASE_RR_EN
        rr_d        = rr_q;
`endif
        if (load && any_eligible) begin
            rel_valid_d = 1'b1;
            rel_iid_d   = winner;
            set_mask    = iid_to_onehot(winner);
`ifdef SIMMEM_RELEASE_RR_EN
            rr_d        = (winner == IidW'(Capa - 1)) ? '0 : (winner + IidW'(1));
`endif
        end else if (load) begin
            rel_valid_d = 1'b0;
        end else begin
            // Back-pressure: hold the presented IID, no new selection.
            rel_valid_d = rel_valid_q;
        end
        // A freed slot loses its grant; a new grant needs slot_valid high,
        // so set and clear never target the same bit.
        granted_d = (granted_q & slot_valid_mhot_i) | set_mask;
        pending_d = popcount(granted_d);
    end

    // Registered state with synchronous active-high reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rel_valid_q <= 1'b0;
            rel_iid_q   <= '0;
            granted_q   <= '0;
            pending_q   <= '0;
`ifdef SIMMEM_RELEASE_RR_EN
            rr_q        <= '0;
`endif
        end else begin
            rel_valid_q <= rel_valid_d;
            rel_iid_q   <= rel_iid_d;
            granted_q   <= granted_d;
            pending_q   <= pending_d;
`ifdef SIMMEM_RELEASE_RR_EN
            rr_q        <= rr_d;
`endif
        end
    end

    // Release confirmation pulses only on the accepting handshake cycle.
    always_comb begin
        released_iid_onehot_o = '0;
        if (rel_valid_q && rel_ready_i) begin
            released_iid_onehot_o = iid_to_onehot(rel_iid_q);
        end else begin
            released_iid_onehot_o = '0;
        end
    end

    assign rel_valid_o   = rel_valid_q;
    assign rel_iid_o     = rel_iid_q;
    assign pending_cnt_o = pending_q;

endmodule

// File: tb/tb_simmem_release_arbiter.sv
// Directed testbench for simmem_release_arbiter (Capa = 16).
// Expected values are hand-computed; round-robin-dependent orders are
// selected with SIMMEM_RELEASE_RR_EN.
`timescale 1ns/1ps

module tb_simmem_release_arbiter;

    localparam int Capa = 16;
    localparam int IidW = 4;

`ifdef SIMMEM_RELEASE_RR_EN
    localparam int FULL_START  = 2;
    localparam int WRAP_FIRST  = 15;
    localparam int WRAP_SECOND = 0;
`else
    localparam int FULL_START  = 0;
    localparam int WRAP_FIRST  = 0;
    localparam int WRAP_SECOND = 15;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [Capa-1:0]   release_en;
    logic [Capa-1:0]   slot_valid;
    logic              rel_valid;
    logic [IidW-1:0]   rel_iid;
    logic              rel_ready;
    logic [Capa-1:0]   onehot;
    logic [IidW:0]     pending;

    int vectors     = 0;
    int miscompares = 0;

    simmem_release_arbiter #(.Capa(Capa)) dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .release_en_mhot_i     (release_en),
        .slot_valid_mhot_i     (slot_valid),
        .rel_valid_o           (rel_valid),
        .rel_iid_o             (rel_iid),
        .rel_ready_i           (rel_ready),
        .released_iid_onehot_o (onehot),
        .pending_cnt_o         (pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic exp_valid,
                             input int exp_iid, input logic [31:0] exp_onehot);
        check({tag, "_valid"}, 32'(rel_valid), 32'(exp_valid));
        check({tag, "_iid"}, 32'(rel_iid), 32'(exp_iid));
        check({tag, "_onehot"}, 32'(onehot), exp_onehot);
    endtask

    initial begin
        rst        = 1'b1;
        release_en = '0;
        slot_valid = '0;
        rel_ready  = 1'b1;
        tick();
        tick();
        check_out("reset", 1'b0, 0, 32'h0);
        check("reset_pending", 32'(pending), 32'd0);
        rst = 1'b0;
        tick();
        check_out("idle", 1'b0, 0, 32'h0);

        // Two slots, continuous ready: IID 0 then IID 2.
        release_en = 16'h0005;
        slot_valid = 16'h0005;
        tick();
        check_out("t1_first", 1'b1, 0, 32'h0001);
        tick();
        check_out("t1_second", 1'b1, 2, 32'h0004);
        tick();
        check("t1_drained_valid", 32'(rel_valid), 32'd0);
        check("t1_drained_onehot", 32'(onehot), 32'h0);
        check("t1_pending", 32'(pending), 32'd2);
        slot_valid = 16'h0000;
        release_en = 16'h0000;
        tick();
        tick();
        check("t1_freed", 32'(pending), 32'd0);

        // Back-pressure on IID 3 with a competing slot 1 arriving meanwhile.
        rel_ready  = 1'b0;
        release_en = 16'h0008;
        slot_valid = 16'h0008;
        tick();
        check_out("t2_present", 1'b1, 3, 32'h0);
        release_en = 16'h000A;
        slot_valid = 16'h000A;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_out("t2_hold", 1'b1, 3, 32'h0);
        end
        check("t2_pending", 32'(pending), 32'd1);
        rel_ready = 1'b1;
        #1;
        check("t2_accept_onehot", 32'(onehot), 32'h0008);
        tick();
        check_out("t2_next", 1'b1, 1, 32'h0002);
        tick();
        check_out("t2_drained", 1'b0, 1, 32'h0);
        check("t2_pending2", 32'(pending), 32'd2);
        release_en = 16'h0000;
        slot_valid = 16'h0000;
        tick();
        tick();
        check("t2_freed", 32'(pending), 32'd0);

        // All sixteen slots eligible: sixteen distinct IIDs back to back.
        release_en = 16'hFFFF;
        slot_valid = 16'hFFFF;
        for (int i = 0; i < Capa; i++) begin
            tick();
            check_out("t3_full", 1'b1, (FULL_START + i) % Capa,
                      32'd1 << ((FULL_START + i) % Capa));
        end
        tick();
        check("t3_done_valid", 32'(rel_valid), 32'd0);
        check("t3_done_onehot", 32'(onehot), 32'h0);
        check("t3_pending", 32'(pending), 32'd16);
        release_en = 16'h0000;
        slot_valid = 16'h0000;
        tick();
        tick();
        check("t3_freed", 32'(pending), 32'd0);

        // Slot 5 stays enabled and valid: presented exactly once until freed.
        release_en = 16'h0020;
        slot_valid = 16'h0020;
        tick();
        check_out("t4_first", 1'b1, 5, 32'h0020);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t4_no_repeat", 32'(rel_valid), 32'd0);
        end
        slot_valid = 16'h0000;
        tick();
        slot_valid = 16'h0020;
        tick();
        check_out("t4_reuse", 1'b1, 5, 32'h0020);
        tick();
        check("t4_reuse_drained", 32'(rel_valid), 32'd0);
        release_en = 16'h0000;
        slot_valid = 16'h0000;
        tick();
        tick();

        // IID 15 accepted, then slots {0,15} eligible.
        release_en = 16'h8000;
        slot_valid = 16'h8000;
        tick();
        check_out("t5_iid15", 1'b1, 15, 32'h8000);
        tick();
        slot_valid = 16'h0000;
        tick();
        release_en = 16'h8001;
        slot_valid = 16'h8001;
        tick();
        check_out("t5_after15_a", 1'b1, 0, 32'h0001);
        tick();
        check_out("t5_after15_b", 1'b1, 15, 32'h8000);
        release_en = 16'h0000;
        slot_valid = 16'h0000;
        tick();
        tick();

        // Pointer parked at 15 (round-robin), then slots {15,0}.
        release_en = 16'h4000;
        slot_valid = 16'h4000;
        tick();
        check_out("t5_iid14", 1'b1, 14, 32'h4000);
        tick();
        release_en = 16'h8001;
        slot_valid = 16'h8001;
        tick();
        check_out("t5_wrap_a", 1'b1, WRAP_FIRST, 32'd1 << WRAP_FIRST);
        tick();
        check_out("t5_wrap_b", 1'b1, WRAP_SECOND, 32'd1 << WRAP_SECOND);
        release_en = 16'h0000;
        slot_valid = 16'h0000;
        tick();
        tick();

        // Slots {3,9}: 3 then 9.
        release_en = 16'h0208;
        slot_valid = 16'h0208;
        tick();
        check_out("t5_pri_a", 1'b1, 3, 32'h0008);
        tick();
        check_out("t5_pri_b", 1'b1, 9, 32'h0200);
        release_en = 16'h0000;
        slot_valid = 16'h0000;
        tick();
        tick();

        // Reset while an IID is presented under back-pressure.
        rel_ready  = 1'b0;
        release_en = 16'h000C;
        slot_valid = 16'h000C;
        tick();
        check_out("t6_present", 1'b1, 2, 32'h0);
        tick();
        check("t6_pending", 32'(pending), 32'd1);
        rst       = 1'b1;
        rel_ready = 1'b1;
        tick();
        check_out("t6_reset", 1'b0, 0, 32'h0);
        check("t6_reset_pending", 32'(pending), 32'd0);
        rst = 1'b0;
        tick();
        check_out("t6_reselect", 1'b1, 2, 32'h0004);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/simmem_release_arbiter.md
# simmem_release_arbiter

Downstream companion of the delay calculator: takes the multi-hot release enables the calculator produces for one response bank (write-response or read-data), selects one releasable slot per cycle, and presents its internal identifier (IID) to the bank output through a registered valid/ready stage. On every accepted release it returns a one-hot released-IID pulse, which the delay calculator consumes as its release confirmation. One instance is used per bank.

## Interface
- Capa, default 16: bank capacity; the number of IID slots. Must be at least 2.
- IidW, default $clog2(Capa): width of the IID. Derived; must not be overridden.

- clk_i, input, 1: clock; all logic is rising-edge.
- rst_i, input, 1: **synchronous, active-high** reset.
- release_en_mhot_i, input, Capa: release enables from the delay calculator; bit k set means slot k's delay has elapsed.
- slot_valid_mhot_i, input, Capa: bank occupancy; bit k set means slot k holds a response.
- rel_valid_o, output, 1: a selected IID is presented.
- rel_iid_o, output, IidW: the selected IID. Stable while rel_valid_o && !rel_ready_i.
- rel_ready_i, input, 1: the bank output accepts the IID.
- released_iid_onehot_o, output, Capa: one-hot release confirmation to the delay calculator, or all-zero.
- pending_cnt_o, output, IidW+1: number of slots currently marked granted.

## Operation
- eligible = release_en_mhot_i & slot_valid_mhot_i & ~granted_q.
- The output register loads when load = !rel_valid_o || (rel_valid_o && rel_ready_i), and eligible is nonzero.
  - On load, the winner index goes to rel_iid_o and rel_valid_o is set.
  - On load, granted_q[winner] is set.
- When load holds and eligible is zero, rel_valid_o clears.
- released_iid_onehot_o is combinational: it equals 1 << rel_iid_o when rel_valid_o && rel_ready_i, else zero. Exactly one cycle per accepted release.
- granted_q[k] clears in the cycle after slot_valid_mhot_i[k] is sampled low, so a freed slot can be reused.
  - A set and a clear of the same bit cannot coincide, because selection requires slot_valid high.
- Selection order is set by the configuration (see below). The round-robin pointer rr_q advances to winner+1 (mod Capa) on each load.
- pending_cnt_o equals the popcount of granted_q, registered.
- A slot is never presented twice while it stays valid. Releases of one slot are not duplicated even if release_en stays asserted.

## Timing
- Reset values: rel_valid_o=0, rel_iid_o=0, released_iid_onehot_o=0, pending_cnt_o=0, granted_q=0, rr_q=0.
- Reset mid-operation drops any presented IID without a confirmation pulse. The delay calculator is reset by the same rst_i.
- Latency: a slot eligible at cycle t appears on rel_valid_o at t+1.
- Throughput: one release per cycle under continuous rel_ready_i.
- Back-pressure: while rel_valid_o && !rel_ready_i, rel_iid_o and rel_valid_o hold, and no new selection is made.
- Full case: all Capa slots eligible drains in exactly Capa accepted cycles, with no repeat.
- Empty case: no eligible slots keeps rel_valid_o low and released_iid_onehot_o zero.
- Wrap-around: the round-robin search continues from rr_q upward modulo Capa. For example, rr_q=Capa-1 with eligible bits {Capa-1, 0} selects Capa-1 first, then 0.

## Configuration
- SIMMEM_RELEASE_RR_EN defined: round-robin selection. The winner is the first eligible index at or after rr_q, modulo Capa.
- SIMMEM_RELEASE_RR_EN undefined: fixed priority, lowest eligible index wins.
  - rr_q is not implemented.
  - All other behaviour is identical.

## Test plan
- Reset, then release_en=0x0005 and slot_valid=0x0005, rel_ready_i=1 -> IID 0 at cycle 1 with onehot 0x0001; IID 2 at cycle 2 with onehot 0x0004; then rel_valid_o=0.
- rel_ready_i held low for 5 cycles with IID 3 presented -> rel_iid_o stays 3; onehot stays 0; pending_cnt_o=1. Ready asserted -> onehot 0x0008 for one cycle.
- Capa=16, all bits eligible, ready=1 -> 16 consecutive distinct IIDs, then rel_valid_o=0 and pending_cnt_o=16. Clear slot_valid -> pending_cnt_o returns to 0.
- release_en held high on slot 5 after acceptance while slot_valid[5] stays 1 -> no second presentation. Drop and re-raise slot_valid[5] -> presented again.
- Round-robin only: after IID 15 is accepted, eligible {0,15} -> 0 selected next. Fixed priority with eligible {3,9} -> 3 then 9.
- rst_i asserted while rel_valid_o=1 -> next cycle all outputs 0 and granted_q cleared.
